parity_tx_ctrl: RTL
===================

PARITY_TX_CTRL -- requirements
Module: parity_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal 2..16).
REQ-002 SHALL have parameter ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 SHALL have parameter DIV, default 4, clock cycles per serial bit (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_in  input  DATA_W  payload, sampled only on acceptance.
REQ-007 SHALL have port valid  input  1  requester has payload on data_in.
REQ-008 SHALL have port ready  output  1  controller can accept a payload.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a payload when valid and ready are both high at a clock edge; that edge SHALL register data_in and its parity bit, and move IDLE->START.
REQ-014 SHALL drive ready high only in IDLE; ready SHALL be registered and not depend combinationally on valid.
REQ-015 SHALL compute the parity bit as XOR of all DATA_W payload bits when ODD=0, and its inverse when ODD=1.
REQ-016 SHALL output frame: start bit 0, payload LSB first, parity bit, stop bit 1; each bit held exactly DIV cycles.
REQ-017 SHALL drive tx low starting the cycle after acceptance; frame length (DATA_W+3)*DIV cycles.
REQ-018 SHALL use a bit-period counter 0..DIV-1 and a bit index 0..DATA_W-1; both clear on every state change; bit index wraps to 0 on DATA->PARITY.
REQ-019 SHALL transition START->DATA, DATA->PARITY (after bit DATA_W-1), PARITY->STOP, STOP->IDLE, each when the period counter reaches DIV-1.
REQ-020 SHALL assert done for exactly the first cycle back in IDLE; ready SHALL be high in that same cycle.
REQ-021 SHALL, with valid held high continuously, accept the next payload in the done cycle, so consecutive frames are separated by exactly one idle cycle with tx=1.
REQ-022 SHALL ignore valid and data_in changes while busy; a held payload is not lost and is accepted on return to IDLE.
REQ-023 SHALL drive busy high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-024 SHALL register tx, ready, busy and done directly from flops (no glitches).

Reset
REQ-025 SHALL on rst high at a clock edge enter IDLE with tx=1, ready=1, busy=0, done=0, counters 0; rst takes precedence over acceptance.
REQ-026 SHALL abort any frame in progress on reset mid-frame: tx=1 the following cycle, no done pulse, partial frame discarded.
REQ-027 SHALL not accept a payload in any cycle where rst is high.

Structure
REQ-028 SHALL take state encodings (3-bit IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and parameter defaults from a shared team constants package/include.
REQ-029 SHALL instantiate one combinational sub-module parity_gen (inputs data, odd; output p) for parity computation; all sequencing stays in parity_tx_ctrl.

Verification
REQ-030 SHALL cover: DIV=4, ODD=0, data_in=0xA5 accepted -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1 each 4 cycles; done one cycle after 44-cycle frame.
REQ-031 SHALL cover: ODD=0 data_in=0x07 -> parity bit 1; ODD=1 data_in=0x07 -> parity bit 0; ODD=1 data_in=0x00 -> parity bit 1.
REQ-032 SHALL cover: valid held high with 0x3C then 0xC3 -> two frames, exactly one tx=1 idle cycle between them, two done pulses 45 cycles apart.
REQ-033 SHALL cover: rst asserted in DATA state on bit 3 -> next cycle tx=1, ready=1, busy=0, no done; new 0x55 frame then completes correctly.
REQ-034 SHALL cover: data_in changed 0xA5->0xFF mid-frame -> transmitted bits still those of 0xA5; DIV=1 frame of 0x01 lasts 11 cycles.

Source files
------------

// File: rtl/parity_tx_ctrl_pkg.sv
// Shared constants for the parity serial transmitter: state encodings,
// parameter defaults and the parity helper used by parity_gen.
package parity_tx_ctrl_pkg;

  // Default payload width, parity sense and bit period
  localparam int DATA_W_DEFAULT = 8;
  localparam int ODD_DEFAULT    = 0;
  localparam int DIV_DEFAULT    = 4;

  // Bit-period counter width, wide enough for DIV up to 255
  localparam int CNT_W = 8;

  // Widest payload the parity helper accepts
  localparam int PAR_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // XOR-reduce a zero-extended payload; the zero padding does not disturb
  // the result. The odd flag inverts the even-parity bit.
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage : parity_tx_ctrl_pkg

// File: rtl/parity_tx_ctrl_parity_gen.sv
// Combinational parity bit generator for one payload word.
module parity_gen
  import parity_tx_ctrl_pkg::*;
#(
  parameter int W = DATA_W_DEFAULT
) (
  input  logic [W-1:0] data,
  input  logic         odd,
  output logic         p
);

  logic [PAR_MAX_W-1:0] data_ext_s;

  // Zero-extend the payload to the helper width and reduce it to one bit
  always_comb begin
    data_ext_s = '0;
    data_ext_s[W-1:0] = data;
    p = parity_of(data_ext_s, odd);
  end

endmodule : parity_gen

// File: rtl/parity_tx_ctrl.sv
// Serial transmitter: start bit, payload LSB first, parity bit, stop bit,
// each bit held DIV cycles. All outputs come straight from flops.
module parity_tx_ctrl
  import parity_tx_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ODD    = ODD_DEFAULT,
  parameter int DIV    = DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                odd_s;
  logic                par_s;
  logic                period_end_s;
  logic [IDX_W-1:0]    idx_inc_s;

  assign odd_s = (ODD != 0) ? 1'b1 : 1'b0;

  parity_gen #(.W(DATA_W)) u_parity_gen (
    .data (data_in),
    .odd  (odd_s),
    .p    (par_s)
  );

  // Next-state and next-output logic; tx_d is the level for the next cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    par_d        = par_q;
    tx_d         = tx_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    period_end_s = (cnt_q == CNT_LAST);
    idx_inc_s    = idx_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (valid && ready_q) begin
          // Acceptance: capture payload and its parity, start bit next cycle
          state_d = ST_START;
          data_d  = data_in;
          par_d   = par_s;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end

      ST_START: begin
        if (period_end_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = data_q[0];
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (period_end_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_PARITY;
            idx_d   = '0;
            tx_d    = par_q;
          end else begin
            idx_d   = idx_inc_s;
            tx_d    = data_q[idx_inc_s];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (period_end_s) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (period_end_s) begin
          // Frame complete: the first idle cycle carries done and ready
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and wins over acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : parity_tx_ctrl
